// File: rtl/qspi_ctrl_pkg.sv
// rtl/qspi_ctrl_pkg.sv - shared types and constants for the QSPI RAM arbiter
package qspi_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_DONE
    } state_t;

    localparam logic [7:0] DEF_CMD_RD = 8'h03;
    localparam logic [7:0] DEF_CMD_WR = 8'h02;

    localparam logic [2:0] CMD_NIB  = 3'd2;
    localparam logic [2:0] ADDR_NIB = 3'd6;
    localparam logic [2:0] DATA_NIB = 3'd2;

    // Pick nibble idx (0 = least significant) out of a 24-bit word
    function automatic logic [3:0] nib_sel(input logic [23:0] v, input logic [2:0] idx);
        logic [3:0] n;
        case (idx)
            3'd0:    n = v[3:0];
            3'd1:    n = v[7:4];
            3'd2:    n = v[11:8];
            3'd3:    n = v[15:12];
            3'd4:    n = v[19:16];
            default: n = v[23:20];
        endcase
        return n;
    endfunction

endpackage

// File: rtl/qspi_ram_arb.sv
// rtl/qspi_ram_arb.sv - two-way grant logic, fixed A>B or round-robin under QSPI_ARB_RR_EN
module qspi_ram_arb (
`ifdef QSPI_ARB_RR_EN
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_take,
`endif
    input  logic       i_a_req,
    input  logic       i_b_req,
    output logic [1:0] o_gnt
);

`ifdef QSPI_ARB_RR_EN
    logic r_prio_b;

    // Priority flips to the port that was not just granted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio_b <= 1'b0;
        end else if (i_take) begin
            r_prio_b <= o_gnt[0];
        end
    end

    // Tie broken by the priority pointer; a lone requester always wins
    always_comb begin
        o_gnt = 2'b00;
        if (i_a_req && i_b_req) begin
            o_gnt = r_prio_b ? 2'b10 : 2'b01;
        end else if (i_a_req) begin
            o_gnt = 2'b01;
        end else if (i_b_req) begin
            o_gnt = 2'b10;
        end
    end
`else
    // Port A always beats port B
    always_comb begin
        o_gnt = 2'b00;
        if (i_a_req) begin
            o_gnt = 2'b01;
        end else if (i_b_req) begin
            o_gnt = 2'b10;
        end
    end
`endif

endmodule

// File: rtl/qspi_ram_arbiter.sv
// rtl/qspi_ram_arbiter.sv - two-port QSPI RAM arbiter and quad transaction sequencer (QSPI_ARB_RR_EN selects round-robin)
module qspi_ram_arbiter
    import qspi_ctrl_pkg::*;
#(
    parameter int         ADDR_W    = 16,
    parameter int         DUMMY_NIB = 2,
    parameter logic [7:0] CMD_RD    = DEF_CMD_RD,
    parameter logic [7:0] CMD_WR    = DEF_CMD_WR
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [7:0]        a_wdata,
    output logic              a_ack,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [7:0]        b_wdata,
    output logic              b_ack,
    output logic [7:0]        rdata,
    output logic              busy,
    output logic              cs_n,
    output logic              sclk,
    output logic [3:0]        io_do,
    output logic [3:0]        io_oe,
    input  logic [3:0]        io_di
);

    localparam logic [2:0] DUMMY_LAST = 3'(DUMMY_NIB - 1);

    state_t      r_state;
    state_t      w_state_nx;
    logic [2:0]  r_cnt;
    logic [2:0]  w_cnt_nx;
    logic        r_phase;
    logic        w_phase_nx;
    logic        r_sel_b;
    logic        r_we;
    logic [23:0] r_addr;
    logic [7:0]  r_wdata;
    logic [7:0]  r_rdata;
    logic [3:0]  r_rx;
    logic [1:0]  w_gnt;
    logic        w_take;
    logic        w_last_nib;
    logic [7:0]  w_cmd;

    qspi_ram_arb u_arb (
`ifdef QSPI_ARB_RR_EN
        .clk     (clk),
        .rst_n   (rst_n),
        .i_take  (w_take),
`endif
        .i_a_req (a_req),
        .i_b_req (b_req),
        .o_gnt   (w_gnt)
    );

    assign w_take = (r_state == ST_IDLE) && (w_gnt != 2'b00);
    assign w_cmd  = r_we ? CMD_WR : CMD_RD;
    assign busy   = ~cs_n;
    assign rdata  = r_rdata;

    // Sequencer state, nibble counter and sclk phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 3'd0;
            r_phase <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_phase <= w_phase_nx;
        end
    end

    // Latch the winner's request at grant; shift in read nibbles at the end of sclk-high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel_b <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= 24'd0;
            r_wdata <= 8'd0;
            r_rx    <= 4'd0;
            r_rdata <= 8'd0;
        end else begin
            if (w_take) begin
                r_sel_b <= w_gnt[1];
                r_we    <= w_gnt[1] ? b_we : a_we;
                r_addr  <= w_gnt[1] ? 24'(b_addr) : 24'(a_addr);
                r_wdata <= w_gnt[1] ? b_wdata : a_wdata;
            end
            if (r_state == ST_DATA && !r_we && r_phase) begin
                r_rx <= io_di;
                if (r_cnt == DATA_NIB - 3'd1) begin
                    r_rdata <= {r_rx, io_di};
                end
            end
        end
    end

    // Next state plus pin and ack decode from the current state
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_phase_nx = r_phase;
        w_last_nib = 1'b0;
        cs_n       = 1'b1;
        sclk       = 1'b0;
        io_oe      = 4'h0;
        io_do      = 4'h0;
        a_ack      = 1'b0;
        b_ack      = 1'b0;

        case (r_state)
            ST_CMD:   w_last_nib = (r_cnt == CMD_NIB - 3'd1);
            ST_ADDR:  w_last_nib = (r_cnt == ADDR_NIB - 3'd1);
            ST_DUMMY: w_last_nib = (r_cnt == DUMMY_LAST);
            ST_DATA:  w_last_nib = (r_cnt == DATA_NIB - 3'd1);
            default:  w_last_nib = 1'b0;
        endcase

        case (r_state)
            ST_IDLE: begin
                if (w_take) begin
                    w_state_nx = ST_CMD;
                    w_cnt_nx   = 3'd0;
                    w_phase_nx = 1'b0;
                end
            end
            ST_DONE: begin
                w_state_nx = ST_IDLE;
                a_ack      = ~r_sel_b;
                b_ack      = r_sel_b;
            end
            default: begin
                cs_n       = 1'b0;
                sclk       = r_phase;
                w_phase_nx = ~r_phase;
                if (r_phase) begin
                    if (w_last_nib) begin
                        w_cnt_nx = 3'd0;
                        case (r_state)
                            ST_CMD:   w_state_nx = ST_ADDR;
                            ST_ADDR:  w_state_nx = (r_we || DUMMY_NIB == 0) ? ST_DATA : ST_DUMMY;
                            ST_DUMMY: w_state_nx = ST_DATA;
                            default:  w_state_nx = ST_DONE;
                        endcase
                    end else begin
                        w_cnt_nx = r_cnt + 3'd1;
                    end
                end
                case (r_state)
                    ST_CMD: begin
                        io_oe = 4'hF;
                        io_do = r_cnt[0] ? w_cmd[3:0] : w_cmd[7:4];
                    end
                    ST_ADDR: begin
                        io_oe = 4'hF;
                        io_do = nib_sel(r_addr, ADDR_NIB - 3'd1 - r_cnt);
                    end
                    ST_DATA: begin
                        if (r_we) begin
                            io_oe = 4'hF;
                            io_do = r_cnt[0] ? r_wdata[3:0] : r_wdata[7:4];
                        end
                    end
                    default: begin
                        io_oe = 4'h0;
                    end
                endcase
            end
        endcase
    end

endmodule

// File: tb/tb_qspi_ram_arbiter.sv
// tb/tb_qspi_ram_arbiter.sv - directed self-checking bench for qspi_ram_arbiter
module tb_qspi_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_req = 1'b0, a_we = 1'b0;
    logic [15:0] a_addr = 16'h0;
    logic [7:0]  a_wdata = 8'h0;
    logic        b_req = 1'b0, b_we = 1'b0;
    logic [15:0] b_addr = 16'h0;
    logic [7:0]  b_wdata = 8'h0;
    logic        a_ack, b_ack, busy, cs_n, sclk;
    logic [7:0]  rdata;
    logic [3:0]  io_do, io_oe;
    logic [3:0]  io_di = 4'h0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    qspi_ram_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(a_ack),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(b_ack),
        .rdata(rdata), .busy(busy), .cs_n(cs_n), .sclk(sclk),
        .io_do(io_do), .io_oe(io_oe), .io_di(io_di)
    );

    // QSPI RAM model: samples on sclk rise, drives read nibbles during sclk-high
    logic [7:0]  mem [0:65535];
    int          m_k = 0;
    logic [7:0]  m_cmd = 8'h0;
    logic [23:0] m_addr = 24'h0;
    logic [3:0]  m_hi = 4'h0;
    logic [3:0]  log_do [$];
    logic [3:0]  log_oe [$];

    always @(posedge sclk or posedge cs_n) begin
        if (cs_n) begin
            m_k = 0;
        end else begin
            log_do.push_back(io_do);
            log_oe.push_back(io_oe);
            if (m_k < 2) m_cmd = {m_cmd[3:0], io_do};
            else if (m_k < 8) m_addr = {m_addr[19:0], io_do};
            else if (m_cmd == 8'h02) begin
                if (m_k == 8) m_hi = io_do;
                else if (m_k == 9) mem[m_addr[15:0]] = {m_hi, io_do};
            end else if (m_cmd == 8'h03) begin
                if (m_k == 10) io_di = mem[m_addr[15:0]][7:4];
                else if (m_k == 11) io_di = mem[m_addr[15:0]][3:0];
            end
            m_k++;
        end
    end

    // Requesters must hold req until ack
    logic a_req_q = 1'b0, b_req_q = 1'b0, a_ack_q = 1'b0, b_ack_q = 1'b0;
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(a_req_q && !a_req && !a_ack && !a_ack_q)) else $error("a_req dropped before a_ack");
            assert (!(b_req_q && !b_req && !b_ack && !b_ack_q)) else $error("b_req dropped before b_ack");
        end
        a_req_q <= a_req;
        b_req_q <= b_req;
        a_ack_q <= a_ack;
        b_ack_q <= b_ack;
    end

    // Length of the most recent cs_n-high run, in clk cycles
    int run_hi = 0;
    int last_gap = 0;
    always @(negedge clk) begin
        if (cs_n) begin
            run_hi <= run_hi + 1;
        end else begin
            if (run_hi > 0) last_gap <= run_hi;
            run_hi <= 0;
        end
    end

    // One transaction on port A or B, started and ended on a negedge
    task automatic do_txn(input bit pb, input bit we, input logic [15:0] addr,
                          input logic [7:0] wd, output int lat, output logic [7:0] rd);
        if (!pb) begin
            a_we = we; a_addr = addr; a_wdata = wd; a_req = 1'b1;
        end else begin
            b_we = we; b_addr = addr; b_wdata = wd; b_req = 1'b1;
        end
        lat = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (pb ? b_ack : a_ack) break;
        end
        rd = rdata;
        if (!pb) a_req = 1'b0;
        else b_req = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({cs_n, sclk, io_oe, io_do, a_ack, b_ack, busy} !== {1'b1, 1'b0, 4'h0, 4'h0, 3'b000}) begin
            n_bad++;
            $display("FAIL reset_pins got %b want %b", {cs_n, sclk, io_oe, io_do, a_ack, b_ack, busy},
                     {1'b1, 1'b0, 4'h0, 4'h0, 3'b000});
        end
        n_cmp++;
        if (rdata !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_rdata got %h want 00", rdata);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write;
        int         lat;
        logic [7:0] rd;
        logic [3:0] exp_w [0:9];
        exp_w = '{4'h0, 4'h2, 4'h0, 4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'hA, 4'h5};
        log_do.delete();
        log_oe.delete();
        do_txn(1'b0, 1'b1, 16'h1234, 8'hA5, lat, rd);
        n_cmp++;
        if (lat !== 21) begin n_bad++; $display("FAIL write_latency got %0d want 21", lat); end
        n_cmp++;
        if (log_do.size() !== 10) begin n_bad++; $display("FAIL write_nib_count got %0d want 10", log_do.size()); end
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if (log_do[i] !== exp_w[i] || log_oe[i] !== 4'hF) begin
                n_bad++;
                $display("FAIL write_nib%0d got do=%h oe=%h want do=%h oe=F", i, log_do[i], log_oe[i], exp_w[i]);
            end
        end
        n_cmp++;
        if (mem[16'h1234] !== 8'hA5) begin n_bad++; $display("FAIL write_mem got %h want a5", mem[16'h1234]); end
    endtask

    task automatic test_read;
        int         lat;
        logic [7:0] rd;
        logic [3:0] exp_r [0:7];
        exp_r = '{4'h0, 4'h3, 4'h0, 4'h0, 4'h1, 4'h2, 4'h3, 4'h4};
        @(negedge clk);
        log_do.delete();
        log_oe.delete();
        do_txn(1'b0, 1'b0, 16'h1234, 8'h00, lat, rd);
        n_cmp++;
        if (lat !== 25) begin n_bad++; $display("FAIL read_latency got %0d want 25", lat); end
        n_cmp++;
        if (rd !== 8'hA5) begin n_bad++; $display("FAIL read_rdata got %h want a5", rd); end
        n_cmp++;
        if (log_do.size() !== 12) begin n_bad++; $display("FAIL read_nib_count got %0d want 12", log_do.size()); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (log_do[i] !== exp_r[i] || log_oe[i] !== 4'hF) begin
                n_bad++;
                $display("FAIL read_nib%0d got do=%h oe=%h want do=%h oe=F", i, log_do[i], log_oe[i], exp_r[i]);
            end
        end
        for (int i = 8; i < 12; i++) begin
            n_cmp++;
            if (log_oe[i] !== 4'h0) begin
                n_bad++;
                $display("FAIL read_oe%0d got %h want 0", i, log_oe[i]);
            end
        end
        repeat (5) @(negedge clk);
        n_cmp++;
        if (rdata !== 8'hA5) begin n_bad++; $display("FAIL read_hold got %h want a5", rdata); end
    endtask

    task automatic test_tie;
        int a_t = 0;
        int b_t = 0;
        int t = 0;
        @(negedge clk);
        a_we = 1'b1; a_addr = 16'h0010; a_wdata = 8'h11; a_req = 1'b1;
        b_we = 1'b1; b_addr = 16'h0020; b_wdata = 8'h22; b_req = 1'b1;
        for (int i = 0; i < 120; i++) begin
            @(posedge clk);
            t++;
            @(negedge clk);
            if (a_ack && a_t == 0) begin
                a_t = t;
                a_req = 1'b0;
            end
            if (b_ack) begin
                b_t = t;
                b_req = 1'b0;
                break;
            end
        end
        a_req = 1'b0;
        b_req = 1'b0;
        n_cmp++;
        if (a_t !== 21) begin n_bad++; $display("FAIL tie_a_ack_time got %0d want 21", a_t); end
        n_cmp++;
        if (b_t !== 43) begin n_bad++; $display("FAIL tie_b_ack_time got %0d want 43", b_t); end
        n_cmp++;
        if (mem[16'h0010] !== 8'h11 || mem[16'h0020] !== 8'h22) begin
            n_bad++;
            $display("FAIL tie_mem got %h/%h want 11/22", mem[16'h0010], mem[16'h0020]);
        end
    endtask

    task automatic test_back_to_back;
        int         lat;
        logic [7:0] rd;
        @(posedge clk);
        @(negedge clk);
        do_txn(1'b1, 1'b0, 16'h0020, 8'h00, lat, rd);
        n_cmp++;
        if (last_gap !== 2) begin n_bad++; $display("FAIL b2b_cs_gap got %0d want 2", last_gap); end
        n_cmp++;
        if (lat !== 25) begin n_bad++; $display("FAIL b2b_latency got %0d want 25", lat); end
        n_cmp++;
        if (rd !== 8'h22) begin n_bad++; $display("FAIL b2b_rdata got %h want 22", rd); end
    endtask

    task automatic test_reset_mid;
        int         lat;
        logic [7:0] rd;
        bit         ack_seen = 1'b0;
        @(negedge clk);
        a_we = 1'b0; a_addr = 16'h0010; a_req = 1'b1;
        repeat (8) @(posedge clk);
        #2;
        n_cmp++;
        if ({cs_n, sclk} !== 2'b01) begin n_bad++; $display("FAIL rstmid_pre got %b want 01", {cs_n, sclk}); end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({cs_n, sclk, io_oe, busy, a_ack} !== {1'b1, 1'b0, 4'h0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL rstmid_async got %b want %b", {cs_n, sclk, io_oe, busy, a_ack},
                     {1'b1, 1'b0, 4'h0, 1'b0, 1'b0});
        end
        a_req = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (a_ack || b_ack) ack_seen = 1'b1;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (a_ack || b_ack) ack_seen = 1'b1;
        end
        n_cmp++;
        if (ack_seen) begin n_bad++; $display("FAIL rstmid_no_ack got 1 want 0"); end
        do_txn(1'b0, 1'b0, 16'h0010, 8'h00, lat, rd);
        n_cmp++;
        if (lat !== 25 || rd !== 8'h11) begin
            n_bad++;
            $display("FAIL rstmid_reread got lat=%0d rd=%h want lat=25 rd=11", lat, rd);
        end
    endtask

    task automatic test_idle;
        int bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (cs_n !== 1'b1 || sclk !== 1'b0 || busy !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin n_bad++; $display("FAIL idle_pins got %0d bad cycles want 0", bad); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_tie();
        test_back_to_back();
        test_reset_mid();
        test_idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
